// File: rtl/tx_port_gate_reader_256_if.sv
// Gate FIFO read port plus the header, data and done outputs of the TX gate reader.
// The DUT uses the slave modport. A driver or testbench uses the master modport.
interface tx_port_gate_reader_256_if #(
  parameter int C_DATA_WIDTH = 256
);
  logic [C_DATA_WIDTH:0]   RD_DATA;
  logic                    RD_EMPTY;
  logic                    RD_EN;
  logic                    TXN;
  logic                    TXN_ACK;
  logic [31:0]             TXN_LEN;
  logic [30:0]             TXN_OFF;
  logic                    TXN_LAST;
  logic [C_DATA_WIDTH-1:0] DATA;
  logic                    DATA_VALID;
  logic                    DATA_REN;
  logic                    TXN_DONE;
  logic [31:0]             TXN_WORDS;
  logic                    ERR;

  modport slave (
    input  RD_DATA, RD_EMPTY, TXN_ACK, DATA_REN,
    output RD_EN, TXN, TXN_LEN, TXN_OFF, TXN_LAST, DATA, DATA_VALID,
           TXN_DONE, TXN_WORDS, ERR
  );

  modport master (
    output RD_DATA, RD_EMPTY, TXN_ACK, DATA_REN,
    input  RD_EN, TXN, TXN_LEN, TXN_OFF, TXN_LAST, DATA, DATA_VALID,
           TXN_DONE, TXN_WORDS, ERR
  );
endinterface

// File: rtl/tx_port_gate_reader_256.sv
// Decodes the TX gate FIFO stream (H, D*, E, E) into a header handshake,
// a one-slot data stream and a done pulse that carries the beat count.
module tx_port_gate_reader_256 #(
  parameter int C_DATA_WIDTH      = 256,
  parameter int C_FIFO_DATA_WIDTH = C_DATA_WIDTH + 1
) (
  input logic                      CLK,
  input logic                      RST,
  tx_port_gate_reader_256_if.slave gate
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_END2 = 2'd3;

  logic [1:0]              state;
  logic                    txn_p1;
  logic [31:0]             len_p1;
  logic [30:0]             off_p1;
  logic                    last_p1;
  logic [C_DATA_WIDTH-1:0] data_p1;
  logic                    vld_p1;
  logic                    done_p1;
  logic [31:0]             words_p1;
  logic                    err_p1;
  logic [31:0]             beat_cnt;

  logic rd_en;
  logic is_end;
  logic slot_free;
  logic beat_taken;

  // The beat counter wraps modulo 2^32 and raises no flag.
  function automatic logic [31:0] beat_inc(input logic [31:0] cnt);
    return cnt + 32'd1;
  endfunction

  assign is_end     = gate.RD_DATA[C_FIFO_DATA_WIDTH-1];
  assign beat_taken = vld_p1 & gate.DATA_REN;
  assign slot_free  = !vld_p1 | gate.DATA_REN;

  // Pop decision, stage 0. RD_EN is forced low while reset is asserted,
  // because a popped word would be lost.
  always_comb begin
    rd_en = 1'b0;
    if (!RST && !gate.RD_EMPTY) begin
      case (state)
        S_IDLE:  rd_en = 1'b1;
        S_DATA:  rd_en = slot_free;
        S_END2:  rd_en = !vld_p1;
        default: rd_en = 1'b0;
      endcase
    end
  end

  // Registered outputs, stage 1: each popped word shows on the next cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      txn_p1   <= 1'b0;
      len_p1   <= '0;
      off_p1   <= '0;
      last_p1  <= 1'b0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      words_p1 <= '0;
      err_p1   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      done_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_en) begin
            len_p1   <= gate.RD_DATA[63:32];
            off_p1   <= gate.RD_DATA[31:1];
            last_p1  <= gate.RD_DATA[0];
            txn_p1   <= 1'b1;
            beat_cnt <= '0;
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (gate.TXN_ACK) begin
            txn_p1 <= 1'b0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (rd_en && !is_end) begin
            data_p1  <= gate.RD_DATA[C_DATA_WIDTH-1:0];
            vld_p1   <= 1'b1;
            beat_cnt <= beat_inc(beat_cnt);
          end else begin
            if (beat_taken) vld_p1 <= 1'b0;
            if (rd_en)      state  <= S_END2;
          end
        end
        S_END2: begin
          // The closing pop waits for the slot to drain, so DONE always follows the last beat.
          if (beat_taken) vld_p1 <= 1'b0;
          if (rd_en) begin
            if (is_end) begin
              done_p1  <= 1'b1;
              words_p1 <= beat_cnt;
              state    <= S_IDLE;
            end else begin
              err_p1 <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign gate.RD_EN      = rd_en;
  assign gate.TXN        = txn_p1;
  assign gate.TXN_LEN    = len_p1;
  assign gate.TXN_OFF    = off_p1;
  assign gate.TXN_LAST   = last_p1;
  assign gate.DATA       = data_p1;
  assign gate.DATA_VALID = vld_p1;
  assign gate.TXN_DONE   = done_p1;
  assign gate.TXN_WORDS  = words_p1;
  assign gate.ERR        = err_p1;

endmodule

// File: tb/tb_tx_port_gate_reader_256.sv
// Scoreboard bench for tx_port_gate_reader_256. A queue-based FIFO model feeds
// the stream, and a monitor checks headers, beats and done events against expectations.
module tb_tx_port_gate_reader_256;
  localparam int DW = 256;

  logic CLK;
  logic RST;

  tx_port_gate_reader_256_if #(.C_DATA_WIDTH(DW)) gate ();

  tx_port_gate_reader_256 #(.C_DATA_WIDTH(DW)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .gate (gate)
  );

  typedef struct { int tid; logic [31:0] len; logic [30:0] off; logic last; } hdr_t;
  typedef struct { int tid; logic [DW-1:0] d; } beat_t;
  typedef struct { int tid; logic [31:0] words; logic err; } done_t;

  logic [DW:0] fifo[$];
  hdr_t        exp_hdr[$];
  beat_t       exp_data[$];
  done_t       exp_done[$];

  int checks = 0;
  int errors = 0;
  int next_tid = 0;
  int cur_tid = -1;
  int beats = 0;
  int cyc = 0;
  int last_acc = 0;
  bit pop = 0;
  bit drv_en = 0;
  bit full_rate = 0;
  bit ren_toggle = 0;
  bit model_err = 0;
  int empty_pct = 0;
  int ack_pct = 100;
  int ren_pct = 100;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event or timeout, required none at %0t", name, $time);
  endtask

  // Reference model: a transaction is H, nd data words, E, nstray stray words, E.
  task automatic send_txn(input logic [31:0] len, input logic [30:0] off, input logic last,
                          input int nd, input int nstray);
    hdr_t        h;
    beat_t       b;
    done_t       d;
    logic [DW:0] w;
    int          tid;
    tid = next_tid;
    next_tid++;
    h.tid = tid; h.len = len; h.off = off; h.last = last;
    exp_hdr.push_back(h);
    w = {1'($urandom_range(1)), rand_word()};
    w[63:0] = {len, off, last};
    fifo.push_back(w);
    for (int i = 0; i < nd; i++) begin
      b.tid = tid;
      b.d = rand_word();
      exp_data.push_back(b);
      fifo.push_back({1'b0, b.d});
    end
    fifo.push_back({1'b1, rand_word()});
    for (int i = 0; i < nstray; i++) fifo.push_back({1'b0, rand_word()});
    fifo.push_back({1'b1, rand_word()});
    if (nstray > 0) model_err = 1'b1;
    d.tid = tid; d.words = 32'(nd); d.err = model_err;
    exp_done.push_back(d);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_done.size() != 0 || fifo.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) fail_evt("idle_timeout");
    @(negedge CLK);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_rd_en"},      256'(gate.RD_EN),      256'(0));
    chk({p, "_txn"},        256'(gate.TXN),        256'(0));
    chk({p, "_data_valid"}, 256'(gate.DATA_VALID), 256'(0));
    chk({p, "_txn_done"},   256'(gate.TXN_DONE),   256'(0));
    chk({p, "_err"},        256'(gate.ERR),        256'(0));
    chk({p, "_fields"},     256'({gate.TXN_LEN, gate.TXN_OFF, gate.TXN_LAST}), 256'(0));
    chk({p, "_data"},       gate.DATA,             256'(0));
    chk({p, "_txn_words"},  256'(gate.TXN_WORDS),  256'(0));
  endtask

  // FIFO model and random handshake driver
  initial begin
    forever begin
      @(posedge CLK);
      if (pop && fifo.size() > 0) void'(fifo.pop_front());
      #1;
      if (drv_en) begin
        gate.RD_EMPTY = (fifo.size() == 0) || ($urandom_range(99) < empty_pct);
        gate.RD_DATA  = (fifo.size() > 0) ? fifo[0] : '0;
        gate.TXN_ACK  = ($urandom_range(99) < ack_pct);
        gate.DATA_REN = ren_toggle ? !gate.DATA_REN : ($urandom_range(99) < ren_pct);
      end
    end
  end

  // Scoreboard monitor
  initial begin
    hdr_t  h;
    done_t d;
    forever begin
      @(negedge CLK);
      cyc++;
      pop = gate.RD_EN;
      if (drv_en && !RST) begin
        if (gate.RD_EMPTY) chk("rd_en_when_empty", 256'(gate.RD_EN), 256'(0));
        if (gate.TXN) begin
          chk("rd_en_in_hdr", 256'(gate.RD_EN), 256'(0));
          chk("data_before_ack", 256'(gate.DATA_VALID), 256'(0));
          if (exp_hdr.size() == 0) begin
            fail_evt("unexpected_txn");
          end else begin
            h = exp_hdr[0];
            chk("txn_fields", 256'({gate.TXN_LEN, gate.TXN_OFF, gate.TXN_LAST}),
                256'({h.len, h.off, h.last}));
            if (gate.TXN_ACK) begin
              void'(exp_hdr.pop_front());
              cur_tid = h.tid;
              beats = 0;
            end
          end
        end
        if (gate.DATA_VALID) begin
          if (exp_data.size() == 0 || exp_data[0].tid != cur_tid) begin
            fail_evt("unexpected_data");
          end else begin
            chk("data", gate.DATA, exp_data[0].d);
            if (gate.DATA_REN) begin
              if (full_rate && beats > 0) chk("back_to_back", 256'(cyc - last_acc), 256'(1));
              last_acc = cyc;
              beats++;
              void'(exp_data.pop_front());
            end
          end
        end
        if (gate.TXN_DONE) begin
          if (exp_done.size() == 0) begin
            fail_evt("unexpected_done");
          end else begin
            d = exp_done.pop_front();
            chk("done_tid", 256'(cur_tid), 256'(d.tid));
            chk("txn_words", 256'(gate.TXN_WORDS), 256'(d.words));
            chk("beats_before_done", 256'(beats), 256'(d.words));
            chk("err", 256'(gate.ERR), 256'(d.err));
          end
        end
      end
    end
  end

  initial begin
    int n;
    RST = 1'b1;
    gate.RD_EMPTY = 1'b0;
    gate.RD_DATA  = {1'b0, rand_word()};
    gate.TXN_ACK  = 1'b1;
    gate.DATA_REN = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_zero("reset");
    gate.RD_EMPTY = 1'b1;
    drv_en = 1'b1;
    @(negedge CLK);
    RST = 1'b0;

    // 1: full rate, ACK and REN always high
    empty_pct = 0; ack_pct = 100; ren_pct = 100; full_rate = 1'b1;
    send_txn(32'd16, 31'd0, 1'b1, 2, 0);
    wait_idle(200);
    full_rate = 1'b0;

    // 2: header held for 5 cycles before ACK
    ack_pct = 0;
    send_txn(32'd16, 31'd0, 1'b1, 2, 0);
    n = 0;
    while (!gate.TXN && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) fail_evt("txn_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("held_txn", 256'(gate.TXN), 256'(1));
      chk("held_rd_en", 256'(gate.RD_EN), 256'(0));
      chk("held_fields", 256'({gate.TXN_LEN, gate.TXN_OFF, gate.TXN_LAST}),
          256'({32'd16, 31'd0, 1'b1}));
      @(negedge CLK);
    end
    ack_pct = 100;
    wait_idle(200);

    // 3: 8 beats with REN toggling
    ren_toggle = 1'b1;
    send_txn(32'd64, 31'h1234, 1'b0, 8, 0);
    wait_idle(400);
    ren_toggle = 1'b0;

    // 4: zero-data transaction
    send_txn(32'd0, 31'h55, 1'b1, 0, 0);
    wait_idle(200);

    // 5: stray D between the two end markers, then a clean transaction
    send_txn(32'd8, 31'h10, 1'b0, 1, 1);
    send_txn(32'd12, 31'h20, 1'b1, 3, 0);
    wait_idle(400);

    // Random traffic
    for (int t = 0; t < 25; t++) begin
      empty_pct = int'($urandom_range(40));
      ack_pct   = 30 + int'($urandom_range(70));
      ren_pct   = 30 + int'($urandom_range(70));
      send_txn($urandom(), 31'($urandom()), 1'($urandom_range(1)), int'($urandom_range(6)),
               ($urandom_range(9) == 0) ? int'($urandom_range(2, 1)) : 0);
      if ($urandom_range(2) == 0) wait_idle(3000);
    end
    wait_idle(8000);

    // 6: asynchronous reset mid-DATA
    empty_pct = 0; ack_pct = 100; ren_pct = 0;
    send_txn(32'd5, 31'd8, 1'b0, 8, 0);
    n = 0;
    while (!gate.DATA_VALID && n < 100) begin @(negedge CLK); n++; end
    if (n >= 100) fail_evt("data_valid_timeout");
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check_zero("async_rst");
    fifo.delete();
    exp_hdr.delete();
    exp_data.delete();
    exp_done.delete();
    model_err = 1'b0;
    @(negedge CLK);
    check_zero("in_rst");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    ren_pct = 100;
    send_txn(32'd4, 31'd2, 1'b1, 2, 0);
    wait_idle(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
